// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: operand forwarding, load-use/branch bubbles,
// branch flush and a memory-wait FSM with timeout watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic       jumpD,
    input  logic       branch_takenD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] write_reg_addrE,
    input  logic [4:0] write_reg_addrM,
    input  logic [4:0] write_reg_addrW,
    input  logic       reg_writeE,
    input  logic       reg_writeM,
    input  logic       reg_writeW,
    input  logic       mem_to_regE,
    input  logic       mem_to_regM,
    input  logic       mem_reqM,
    input  logic       dm_ready,
    output logic [1:0] fwdAE,
    output logic [1:0] fwdBE,
    output logic       fwdAD,
    output logic       fwdBD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic       mem_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
`endif
    output logic       err_timeout
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [TO_CNT_W-1:0] TO_MAX = TO_CNT_W'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                lwstall, brstall, memstall;
    logic                wrM_ok, wrW_ok, wrE_ok;

    assign wrE_ok = write_reg_addrE != 5'd0;
    assign wrM_ok = reg_writeM && write_reg_addrM != 5'd0;
    assign wrW_ok = reg_writeW && write_reg_addrW != 5'd0;

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (wrM_ok && write_reg_addrM == rsE)      fwdAE = 2'b10;
        else if (wrW_ok && write_reg_addrW == rsE) fwdAE = 2'b01;
        if (wrM_ok && write_reg_addrM == rtE)      fwdBE = 2'b10;
        else if (wrW_ok && write_reg_addrW == rtE) fwdBE = 2'b01;
    end

    assign fwdAD = wrM_ok && write_reg_addrM == rsD;
    assign fwdBD = wrM_ok && write_reg_addrM == rtD;

    assign lwstall  = mem_to_regE && wrE_ok &&
                      (write_reg_addrE == rsD || write_reg_addrE == rtD);
    assign brstall  = branchD &&
                      ((reg_writeE && wrE_ok &&
                        (write_reg_addrE == rsD || write_reg_addrE == rtD)) ||
                       (mem_to_regM && write_reg_addrM != 5'd0 &&
                        (write_reg_addrM == rsD || write_reg_addrM == rtD)));
    assign memstall = mem_reqM && !dm_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The watchdog only flags; the wait continues until memory answers.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (memstall) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dm_ready) state_d = RUN;
                cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
                if (cnt_d == TO_MAX) err_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if ((branchD && branch_takenD) || jumpD) begin
            flushD = 1'b1;
        end
    end

    assign mem_busy    = state_q == MEM_WAIT;
    assign err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stallF};
        perf_flush_d = perf_flush_q + {31'd0, flushD | flushE};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`endif

endmodule
